div_issue_ctrl: RTL and testbench
=================================

// Module: div_issue_ctrl
// PURPOSE
//   Issue/retire controller directly upstream of the iterative Divider in the EX-stage MDU.
//   Accepts one RV64M divide op (DIV/DIVU/REM/REMU, +W forms) via valid/ready.
//   Resolves divide-by-zero and signed overflow locally in 1 cycle; otherwise sequences the Divider.
//   Returns one XLEN result to writeback via valid/ready; supports pipeline flush.
// PARAMETERS
//   WIDTH  `XLEN (64)  operand/result width; Divider instance uses same WIDTH; W ops need WIDTH=64
// PORTS
//   clk         in   1      clock
//   rst         in   1      reset, asynchronous, active-high
//   iFlush      in   1      sync abort: drop in-flight op
//   iValid      in   1      op request
//   oReady      out  1      op accepted when iValid&oReady
//   iOp         in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//   iWord       in   1      1 = *W form (32-bit operation, sign-extended result)
//   iRs1/iRs2   in   WIDTH  dividend / divisor
//   oValid      out  1      result valid; held until oValid&iReady
//   iReady      in   1      writeback ready
//   oResult     out  WIDTH  quotient or remainder per iOp
//   oDivValid   out  1      to Divider iValidIn (load)
//   oDivReady   out  1      to Divider iReadyOut (advance)
//   oDivDivd    out  WIDTH  to Divider iDivd
//   oDivDivr    out  WIDTH  to Divider iDivr
//   oDivSigned  out  1      to Divider iSigned
//   iDivValid   in   1      from Divider oValid
//   iDivQuot    in   WIDTH  from Divider oQuot
//   iDivRem     in   WIDTH  from Divider oRem
// BEHAVIOUR
//   Reset: state IDLE; oValid, oDivValid, oDivReady = 0; oResult, latched operands = 0.
//   oReady = (state==IDLE) & !iFlush. No accept in the cycle a result retires.
//   Accept: latch op; W forms: operands = sext32 (DIVW/REMW) or zext32 (DIVUW/REMUW) of low 32.
//   Special-case detect on (possibly narrowed) operands at accept:
//     divisor==0      -> quot = all ones, rem = dividend; W: sext32 of those low-32 values
//     signed, dvd==MIN(WIDTH), dvr==-1 (non-W) -> quot = MIN, rem = 0
//     either -> DONE next cycle (latency 1), Divider untouched.
//   FSM: IDLE -> START (normal op) | DONE (special); START -> BUSY; BUSY -> DONE on iDivValid;
//        DONE -> IDLE on iReady.
//   START: oDivValid=1, oDivReady=1 for exactly one cycle (Divider loads, counter 0).
//   BUSY: oDivValid=0; oDivReady = !iDivValid (combinational) so Divider freezes on completion;
//         iDivValid sampled only in BUSY; stale iDivValid outside BUSY ignored.
//   Capture on BUSY&iDivValid: oResult = iOp[1] ? iDivRem : iDivQuot; W: sext32 of low 32.
//   W signed overflow needs no special case: 64-bit divide of sext operands yields correct low 32.
//   Latency (accept cycle C): normal -> oValid at C+WIDTH+3 (67 @64); special -> C+1.
//   DONE: oValid=1, oResult stable until iReady; iReady low = indefinite hold.
//   iFlush (any state): next state IDLE, oValid=0, oDivReady=0 same cycle; result discarded.
//   iFlush & iValid same cycle: op not accepted. Flush in START/BUSY: Divider left frozen,
//   reloaded by next START.
//   Async rst mid-op: immediate return to reset values; no result emitted.
// TESTING
//   DIVU 100/7 -> oResult 14 at C+67; REMU 100/7 -> 2; oDivValid high exactly 1 cycle.
//   DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF.
//   DIV 5/0 -> all ones, REM 5/0 -> 5, both at C+1; oDivValid never asserted.
//   DIV 0x8000_0000_0000_0000/-1 -> 0x8000_0000_0000_0000, REM -> 0, at C+1.
//   DIVW rs1=0x0000_0000_8000_0000 rs2=-1 -> 0xFFFF_FFFF_8000_0000; DIVUW 0x1_0000_0010/2 -> 8.
//   iReady low 5 cycles in DONE -> result held; iFlush at BUSY cycle 10 -> oReady next
//   cycle, next DIVU 9/3 -> 3; rst at BUSY cycle 20 -> all outputs 0, no oValid.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issue/retire controller in front of the iterative divider in the MDU.
// Takes one RV64M divide op (DIV/DIVU/REM/REMU and their W forms) through a valid/ready
// handshake. Divide-by-zero and signed overflow are resolved locally in one cycle. All
// other ops are sequenced through the external divider. One result is returned to
// writeback through a second valid/ready handshake.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   iFlush                    synchronous abort; drops any in-flight op
//   iValid/oReady             op request handshake; iOp, iWord, iRs1, iRs2 are the op fields
//   oValid/iReady, oResult    result handshake to writeback
//   oDivValid, oDivReady      divider load and advance
//   oDivDivd, oDivDivr        divider operands
//   oDivSigned                divider signedness
//   iDivValid, iDivQuot/Rem   divider completion and results
module div_issue_ctrl #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iFlush,
  input  logic             iValid,
  output logic             oReady,
  input  logic [1:0]       iOp,
  input  logic             iWord,
  input  logic [WIDTH-1:0] iRs1,
  input  logic [WIDTH-1:0] iRs2,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oResult,
  output logic             oDivValid,
  output logic             oDivReady,
  output logic [WIDTH-1:0] oDivDivd,
  output logic [WIDTH-1:0] oDivDivr,
  output logic             oDivSigned,
  input  logic             iDivValid,
  input  logic [WIDTH-1:0] iDivQuot,
  input  logic [WIDTH-1:0] iDivRem
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StBusy  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] sext32(input logic [WIDTH-1:0] x);
    return {{(WIDTH-32){x[31]}}, x[31:0]};
  endfunction

  function automatic logic [WIDTH-1:0] zext32(input logic [WIDTH-1:0] x);
    return {{(WIDTH-32){1'b0}}, x[31:0]};
  endfunction

  logic [1:0]       state_q, state_d;
  logic             rem_q, rem_d;
  logic             word_q, word_d;
  logic             signed_q, signed_d;
  logic [WIDTH-1:0] divd_q, divd_d;
  logic [WIDTH-1:0] divr_q, divr_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] rs1_n, rs2_n;
  logic             is_signed, div_zero, sgn_ovf;
  logic [WIDTH-1:0] spec_res, div_res;

  // Operand narrowing and special-case detection on the incoming op.
  always_comb begin
    is_signed = ~iOp[0];
    rs1_n     = iRs1;
    rs2_n     = iRs2;
    if (iWord) begin
      rs1_n = is_signed ? sext32(iRs1) : zext32(iRs1);
      rs2_n = is_signed ? sext32(iRs2) : zext32(iRs2);
    end
    div_zero = (rs2_n == '0);
    // W forms never overflow here: the full-width divide of sign-extended
    // operands already yields the correct low 32 bits.
    sgn_ovf  = is_signed & ~iWord & (rs1_n == MinVal) & (rs2_n == '1);
    if (div_zero) begin
      spec_res = iOp[1] ? rs1_n : '1;
    end else begin
      spec_res = iOp[1] ? '0 : MinVal;
    end
    if (iWord) spec_res = sext32(spec_res);
    div_res = rem_q ? iDivRem : iDivQuot;
    if (word_q) div_res = sext32(div_res);
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    word_d   = word_q;
    signed_d = signed_q;
    divd_d   = divd_q;
    divr_d   = divr_q;
    result_d = result_q;
    if (iFlush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (iValid) begin
            rem_d    = iOp[1];
            word_d   = iWord;
            signed_d = is_signed;
            divd_d   = rs1_n;
            divr_d   = rs2_n;
            if (div_zero || sgn_ovf) begin
              result_d = spec_res;
              state_d  = StDone;
            end else begin
              state_d = StStart;
            end
          end
        end
        StStart: state_d = StBusy;
        StBusy: begin
          if (iDivValid) begin
            result_d = div_res;
            state_d  = StDone;
          end
        end
        StDone: begin
          if (iReady) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rem_q    <= 1'b0;
      word_q   <= 1'b0;
      signed_q <= 1'b0;
      divd_q   <= '0;
      divr_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      word_q   <= word_d;
      signed_q <= signed_d;
      divd_q   <= divd_d;
      divr_q   <= divr_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    oReady     = (state_q == StIdle) & ~iFlush;
    oValid     = (state_q == StDone) & ~iFlush;
    oResult    = result_q;
    oDivValid  = (state_q == StStart);
    // Drop advance as soon as the divider reports done so it freezes on its result.
    oDivReady  = ~iFlush & ((state_q == StStart) | ((state_q == StBusy) & ~iDivValid));
    oDivDivd   = divd_q;
    oDivDivr   = divr_q;
    oDivSigned = signed_q;
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;
  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         iFlush, iValid, oReady, iWord, oValid, iReady;
  logic [1:0]   iOp;
  logic [W-1:0] iRs1, iRs2, oResult;
  logic         oDivValid, oDivReady, oDivSigned, iDivValid;
  logic [W-1:0] oDivDivd, oDivDivr, iDivQuot, iDivRem;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int divv_cnt = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (oDivValid) divv_cnt <= divv_cnt + 1;

  div_issue_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .iFlush(iFlush), .iValid(iValid), .oReady(oReady), .iOp(iOp),
    .iWord(iWord), .iRs1(iRs1), .iRs2(iRs2), .oValid(oValid), .iReady(iReady),
    .oResult(oResult), .oDivValid(oDivValid), .oDivReady(oDivReady), .oDivDivd(oDivDivd),
    .oDivDivr(oDivDivr), .oDivSigned(oDivSigned), .iDivValid(iDivValid),
    .iDivQuot(iDivQuot), .iDivRem(iDivRem)
  );

  // Behavioural iterative divider: loads on valid&ready, then advances one step per
  // cycle while ready; reports done after W steps and freezes there.
  logic     m_busy;
  int       m_cnt;
  assign iDivValid = m_busy && (m_cnt == W);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy   <= 1'b0;
      m_cnt    <= 0;
      iDivQuot <= '0;
      iDivRem  <= '0;
    end else if (oDivValid && oDivReady) begin
      m_busy <= 1'b1;
      m_cnt  <= 0;
      if (oDivSigned) begin
        iDivQuot <= $signed(oDivDivd) / $signed(oDivDivr);
        iDivRem  <= $signed(oDivDivd) % $signed(oDivDivr);
      end else begin
        iDivQuot <= oDivDivd / oDivDivr;
        iDivRem  <= oDivDivd % oDivDivr;
      end
    end else if (m_busy && oDivReady && m_cnt != W) begin
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, then wait for and retire its result, checking latency, value,
  // result hold under back-pressure and number of divider loads.
  task automatic do_op(input string tag, input logic [1:0] op, input logic w,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input int exp_lat, input int exp_divv,
                       input int hold);
    int c0, d0, n;
    bit seen;
    @(negedge clk);
    iOp = op; iWord = w; iRs1 = a; iRs2 = b; iValid = 1'b1;
    iReady = (hold == 0);
    #1;
    n = 0;
    while (!oReady && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_ready"}, W'(oReady), W'(1));
    c0 = cyc;
    d0 = divv_cnt;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    iValid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (oValid) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_seen"}, W'(seen), W'(1));
    check({tag, "_lat"}, W'(cyc - c0), W'(exp_lat));
    for (int k = 0; k < hold; k++) begin
      check({tag, "_hold_v"}, W'(oValid), W'(1));
      check({tag, "_hold_r"}, oResult, exp_q[0]);
      @(negedge clk);
    end
    iReady = 1'b1;
    check({tag, "_res"}, oResult, exp_q.pop_front());
    @(posedge clk); #1;
    check({tag, "_retired"}, W'(oValid), W'(0));
    check({tag, "_divv"}, W'(divv_cnt - d0), W'(exp_divv));
  endtask

  task automatic issue_only(input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b);
    @(negedge clk);
    iOp = op; iWord = 1'b0; iRs1 = a; iRs2 = b; iValid = 1'b1;
    #1;
    check("issue_ready", W'(oReady), W'(1));
    @(posedge clk); #1;
    iValid = 1'b0;
  endtask

  initial begin
    int vcount;
    rst = 1'b1; iFlush = 1'b0; iValid = 1'b0; iReady = 1'b1;
    iOp = 2'b00; iWord = 1'b0; iRs1 = '0; iRs2 = '0;
    #12;
    check("rst_ovalid", W'(oValid), W'(0));
    check("rst_odivvalid", W'(oDivValid), W'(0));
    check("rst_odivready", W'(oDivReady), W'(0));
    check("rst_oresult", oResult, '0);
    check("rst_oready", W'(oReady), W'(1));
    @(negedge clk);
    rst = 1'b0;

    do_op("divu", 2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 67, 1, 0);
    do_op("remu", 2'b11, 1'b0, 64'd100, 64'd7, 64'd2, 67, 1, 0);
    do_op("div_neg", 2'b00, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67, 1, 0);
    do_op("rem_neg", 2'b10, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67, 1, 0);
    do_op("div_zero", 2'b00, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0);
    do_op("rem_zero", 2'b10, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0, 0);
    do_op("div_ovf", 2'b00, 1'b0, 64'h8000_0000_0000_0000, '1,
          64'h8000_0000_0000_0000, 1, 0, 0);
    do_op("rem_ovf", 2'b10, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0, 0);
    do_op("divw", 2'b00, 1'b1, 64'h0000_0000_8000_0000, '1,
          64'hFFFF_FFFF_8000_0000, 67, 1, 0);
    do_op("divuw", 2'b01, 1'b1, 64'h1_0000_0010, 64'd2, 64'd8, 67, 1, 0);
    do_op("remuw_zero", 2'b11, 1'b1, 64'h5_8000_0001, 64'h7_0000_0000,
          64'hFFFF_FFFF_8000_0001, 1, 0, 0);
    do_op("hold", 2'b01, 1'b0, 64'd1000, 64'd10, 64'd100, 67, 1, 5);

    // Flush at BUSY cycle 10.
    issue_only(2'b01, 64'd1000, 64'd3);
    repeat (11) @(negedge clk);
    check("flush_busy_adv", W'(oDivReady), W'(1));
    iFlush = 1'b1;
    iValid = 1'b1;
    #1;
    check("flush_odivready", W'(oDivReady), W'(0));
    check("flush_oready", W'(oReady), W'(0));
    @(posedge clk); #1;
    iFlush = 1'b0;
    iValid = 1'b0;
    #1;
    check("flush_oready_next", W'(oReady), W'(1));
    check("flush_ovalid", W'(oValid), W'(0));
    do_op("after_flush", 2'b01, 1'b0, 64'd9, 64'd3, 64'd3, 67, 1, 0);

    // Asynchronous reset at BUSY cycle 20.
    issue_only(2'b01, 64'd1000, 64'd3);
    repeat (21) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ovalid", W'(oValid), W'(0));
    check("arst_odivvalid", W'(oDivValid), W'(0));
    check("arst_odivready", W'(oDivReady), W'(0));
    check("arst_oresult", oResult, '0);
    check("arst_divd", oDivDivd, '0);
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (oValid) vcount++;
    end
    check("arst_no_result", W'(vcount), W'(0));
    do_op("after_rst", 2'b01, 1'b0, 64'd20, 64'd4, 64'd5, 67, 1, 0);
    check("sb_empty", W'(exp_q.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
